// File: rtl/input_debounce.sv
//------------------------------------------------------------------------------
// Module  : input_debounce
// Purpose : Per-bit two-flop synchronizer and stability-counter debouncer for
//           DIP switches and pushbuttons. Optional registered rise/fall/changed
//           pulses are built only when DEBOUNCE_EDGE_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module input_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int            CW     = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  // Each bit counts consecutive disagreements; any agreement restarts it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [CW-1:0] r_cnt;

    assign w_accept[gi] = (r_s2[gi] != r_stable[gi]) && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if ((r_s2[gi] == r_stable[gi]) || w_accept[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // An accepted bit always disagrees with stable, so toggling takes s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
    end else begin
      r_stable <= r_stable ^ w_accept;
    end
  end

  assign stable = r_stable;

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_accept & r_s2;
      r_fall    <= w_accept & ~r_s2;
      r_changed <= |w_accept;
    end
  end

  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_input_debounce.sv
//------------------------------------------------------------------------------
// Module  : tb_input_debounce
// Purpose : Directed scoreboard bench for input_debounce (WIDTH=8, STABLE_CYCLES=4);
//           edge-pulse expectations follow DEBOUNCE_EDGE_EN.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_input_debounce;

  logic       clk;
  logic       rst_n;
  logic [7:0] raw;
  logic [7:0] stable;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic       ch;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];

  input_debounce #(
    .WIDTH         (8),
    .STABLE_CYCLES (4)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
    .stable  (stable),
    .rise    (rise),
    .fall    (fall),
    .changed (changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge pulses only exist when the feature is built in.
  task automatic push_exp(input logic [7:0] st, input logic [7:0] ri,
                          input logic [7:0] fa, input logic ch, input string tag);
    exp_t e;
    e.st = st;
`ifdef DEBOUNCE_EDGE_EN
    e.ri = ri;
    e.fa = fa;
    e.ch = ch;
`else
    e.ri = 8'h00;
    e.fa = 8'h00;
    e.ch = 1'b0;
`endif
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic pop_chk();
    exp_t  e;
    string t;
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbq.pop_front();
    t = tagq.pop_front();
    chk8({t, "_stable"},  stable,  e.st);
    chk8({t, "_rise"},    rise,    e.ri);
    chk8({t, "_fall"},    fall,    e.fa);
    chk8({t, "_changed"}, {7'd0, changed}, {7'd0, e.ch});
  endtask

  // Drive raw before the next rising edge, then check just after it.
  task automatic cyc(input logic [7:0] r, input logic [7:0] st, input logic [7:0] ri,
                     input logic [7:0] fa, input logic ch, input string tag);
    @(negedge clk);
    raw = r;
    push_exp(st, ri, fa, ch, tag);
    @(posedge clk);
    #1;
    pop_chk();
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = 8'h00;
    #3;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, "reset");
    pop_chk();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "idle");

    // Clean 0x05 press, then release.
    for (int i = 0; i < 5; i++) cyc(8'h05, 8'h00, 8'h00, 8'h00, 1'b0, "t1_hold");
    cyc(8'h05, 8'h05, 8'h05, 8'h00, 1'b1, "t1_accept");
    repeat (3) cyc(8'h05, 8'h05, 8'h00, 8'h00, 1'b0, "t1_after");
    for (int i = 0; i < 5; i++) cyc(8'h00, 8'h05, 8'h00, 8'h00, 1'b0, "t1_relhold");
    cyc(8'h00, 8'h00, 8'h00, 8'h05, 1'b1, "t1_release");
    repeat (2) cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "t1_idle");

    // Glitch one cycle short of acceptance.
    repeat (3) cyc(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, "t2_glitch");
    repeat (10) cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "t2_quiet");

    // Bouncing bit 3, then held high.
    for (int i = 0; i < 20; i++)
      cyc((((i / 2) % 2) == 0) ? 8'h08 : 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "t3_bounce");
    for (int i = 0; i < 5; i++) cyc(8'h08, 8'h00, 8'h00, 8'h00, 1'b0, "t3_settle");
    cyc(8'h08, 8'h08, 8'h08, 8'h00, 1'b1, "t3_accept");
    repeat (2) cyc(8'h08, 8'h08, 8'h00, 8'h00, 1'b0, "t3_after");

    // All bits high, then all low.
    for (int i = 0; i < 5; i++) cyc(8'hFF, 8'h08, 8'h00, 8'h00, 1'b0, "t4_hiwait");
    cyc(8'hFF, 8'hFF, 8'hF7, 8'h00, 1'b1, "t4_hiacc");
    repeat (4) cyc(8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, "t4_hihold");
    for (int i = 0; i < 5; i++) cyc(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, "t4_lowait");
    cyc(8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, "t4_loacc");
    repeat (2) cyc(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "t4_lohold");

    // Reset mid-count discards progress.
    for (int i = 0; i < 4; i++) cyc(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, "t5_count");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, "t5_rst_now");
    pop_chk();
    @(posedge clk);
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, "t5_rst_edge");
    pop_chk();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, "t5_recount");
    cyc(8'h01, 8'h01, 8'h01, 8'h00, 1'b1, "t5_accept");
    cyc(8'h01, 8'h01, 8'h00, 8'h00, 1'b0, "t5_after");

    // Asynchronous reset while stable and a rise pulse are live.
    for (int i = 0; i < 5; i++) cyc(8'h81, 8'h01, 8'h00, 8'h00, 1'b0, "t6_wait");
    cyc(8'h81, 8'h81, 8'h80, 8'h00, 1'b1, "t6_accept");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, "t6_async");
    pop_chk();
    @(posedge clk);
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, "t6_inreset");
    pop_chk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the number of independent switch/button inputs.
REQ-002 The module SHALL have parameter STABLE_CYCLES, default 16, giving the cycles a synchronized input must hold before acceptance; legal range 2..65535.
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have port raw, input, WIDTH bits, asynchronous DIP-switch/pushbutton levels.
REQ-006 The module SHALL have port stable, output, WIDTH bits, the debounced level per bit.
REQ-007 The module SHALL have port rise, output, WIDTH bits, a one-cycle pulse per bit when stable goes 0->1.
REQ-008 The module SHALL have port fall, output, WIDTH bits, a one-cycle pulse per bit when stable goes 1->0.
REQ-009 The module SHALL have port changed, output, 1 bit, the OR of all rise and fall bits in the same cycle.

Function
REQ-010 Each raw bit SHALL pass through a two-flop synchronizer (s1 <= raw, s2 <= s1) before any other use.
REQ-011 Each bit SHALL own an independent counter of $clog2(STABLE_CYCLES) bits; bits SHALL NOT interact.
REQ-012 Per bit, on every edge: if s2 == stable, the counter SHALL clear to 0.
REQ-013 Per bit, if s2 != stable and counter == STABLE_CYCLES-1, stable SHALL take s2, the counter SHALL clear, and the matching rise/fall bit SHALL assert for exactly the next cycle.
REQ-014 Per bit, if s2 != stable and counter < STABLE_CYCLES-1, the counter SHALL increment by 1 and never wrap.
REQ-015 Latency: a raw change first sampled at edge k and held SHALL appear on stable after edge k+STABLE_CYCLES+1.
REQ-016 A bounce returning s2 to the stable value before acceptance SHALL clear the counter; the next disagreement SHALL restart counting from 0.
REQ-017 rise and fall SHALL be registered outputs, never both asserted on one bit, and SHALL deassert on the following edge unless a new acceptance occurs.
REQ-018 Multiple bits accepted on the same edge SHALL each pulse in that same cycle; changed SHALL be a single 1-cycle pulse.
REQ-019 stable SHALL change at most once per bit per STABLE_CYCLES+1 cycles.

Reset
REQ-020 While rst_n is low, s1, s2, stable, all counters, rise, fall, and changed SHALL be 0 immediately, independent of clk.
REQ-021 Reset asserted mid-count SHALL discard the count; after release, a raw bit held at 1 SHALL be accepted as a rise after STABLE_CYCLES+1 edges.
REQ-022 The first edge after rst_n deasserts SHALL be a normal operating edge; no extra recovery cycles are required.

Configuration
REQ-023 With macro DEBOUNCE_EDGE_EN defined, rise, fall, and changed SHALL behave as in REQ-013, REQ-017, and REQ-018.
REQ-024 Without DEBOUNCE_EDGE_EN, rise, fall, and changed SHALL be tied to constant 0, no edge registers SHALL be synthesized, and stable SHALL be unaffected.

Verification (WIDTH=8, STABLE_CYCLES=4, DEBOUNCE_EDGE_EN defined)
REQ-025 The bench SHALL drive raw 0x00->0x05 sampled at edge 0 and held; stable SHALL be 0x00 through edge 4 and 0x05 after edge 5, rise SHALL be 0x05 for one cycle, and changed SHALL pulse once.
REQ-026 The bench SHALL drive raw bit 0 high for 3 cycles, then low; stable, rise, and changed SHALL remain 0 throughout.
REQ-027 The bench SHALL drive raw bit 3 toggling every 2 cycles for 20 cycles, then held high; stable[3] SHALL rise only 5 cycles after the final toggle sample, with exactly one rise pulse.
REQ-028 The bench SHALL drive raw 0xFF for 10 cycles, then 0x00; fall SHALL be 0xFF for exactly one cycle, and rise SHALL stay 0.
REQ-029 The bench SHALL drive raw 0x01, assert rst_n low at counter==2 for 1 cycle, and keep raw 0x01; outputs SHALL be 0 immediately, and stable SHALL become 0x01 5 edges after release.
REQ-030 The bench SHALL rebuild without DEBOUNCE_EDGE_EN and rerun REQ-025; stable timing SHALL be identical, and rise, fall, and changed SHALL stay 0.
